// File: rtl/adder_4bit.sv
// adder_4bit: registered 4-bit two's-complement adder with carry-in.
// An explicit ripple chain of four full adders feeds SUM, a signed overflow
// flag (C3 ^ C4) and the unsigned carry-out (C4). All outputs are registered,
// so there is exactly one cycle of latency and no input-to-output path.
// Optional build macro ADDER_4BIT_SAT_EN clamps SUM on signed overflow
// (0111 for two non-negative operands, 1000 for two negative operands);
// Overflow and Cout are unaffected by the clamp.
module adder_4bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C0,
    output logic [3:0] SUM,
    output logic       Overflow,
    output logic       Cout
);

    // carry[i] is the carry into bit i; carry[4] is the carry-out.
    logic [4:0] carry;
    logic [3:0] raw_sum;

    logic [3:0] sum_d, sum_q;
    logic       ovf_d, ovf_q;
    logic       cout_d, cout_q;

    assign carry[0] = C0;

    // Ripple chain: one full adder per bit, kept explicit so C3 and C4
    // are available by name for the flag logic.
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign raw_sum[i]   = A[i] ^ B[i] ^ carry[i];
        assign carry[i + 1] = (A[i] & B[i]) | (A[i] & carry[i]) | (B[i] & carry[i]);
    end

    // Next-state result: wrapped sum and flags, with optional clamping.
    always_comb begin
        // NOTE: every output of this block is given a value up front, so no
        // path through the optional clamp can leave one unassigned (latch).
        sum_d  = raw_sum;
        ovf_d  = carry[3] ^ carry[4];
        cout_d = carry[4];
`ifdef ADDER_4BIT_SAT_EN
        // Overflow implies A and B share a sign, so A[3] picks the limit.
        if (ovf_d) begin
            sum_d = A[3] ? 4'b1000 : 4'b0111;
        end
`endif
    end

    // Output registers with synchronous reset; reset discards any in-flight result.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            sum_q  <= 4'b0000;
            ovf_q  <= 1'b0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            ovf_q  <= ovf_d;
            cout_q <= cout_d;
        end
    end

    assign SUM      = sum_q;
    assign Overflow = ovf_q;
    assign Cout     = cout_q;

endmodule

// File: tb/tb_adder_4bit.sv
// tb_adder_4bit: directed and exhaustive self-checking bench for adder_4bit.
// Expected values are hand-computed constants for directed vectors and a
// small integer-arithmetic model for the exhaustive sweep.
module tb_adder_4bit;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic       C0;
    logic [3:0] SUM;
    logic       Overflow;
    logic       Cout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       c;
        logic [3:0] sum;
        logic       ovf;
        logic       cout;
    } vec_t;

    adder_4bit dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .C0       (C0),
        .SUM      (SUM),
        .Overflow (Overflow),
        .Cout     (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    // Drive one input set, then advance past the next rising edge.
    task automatic step(input logic [3:0] a, input logic [3:0] b, input logic c);
        A  = a;
        B  = b;
        C0 = c;
        @(posedge clk);
        #1;
    endtask

    // Reference model: integer addition, flags from operand/result signs.
    function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] full;
        logic [3:0] s;
        logic       ovf;
        full = {1'b0, a} + {1'b0, b} + {4'b0000, c};
        s    = full[3:0];
        ovf  = (a[3] == b[3]) && (s[3] != a[3]);
`ifdef ADDER_4BIT_SAT_EN
        if (ovf) s = a[3] ? 4'b1000 : 4'b0111;
`endif
        return {s, ovf, full[4]};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        for (int e = 0; e < 2; e++) begin
            step(4'b1111, 4'b1111, 1'b1);
            checks++;
            if ({SUM, Overflow, Cout} !== 6'b0000_0_0) begin
                errors++;
                $display("FAIL reset_edge%0d: got SUM=%b Ovf=%b Cout=%b, want SUM=0000 Ovf=0 Cout=0",
                         e, SUM, Overflow, Cout);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        vec_t v[5];
        v[0] = '{4'b1001, 4'b0100, 1'b1, 4'b1110, 1'b0, 1'b0};
`ifdef ADDER_4BIT_SAT_EN
        v[1] = '{4'b1100, 4'b1011, 1'b0, 4'b1000, 1'b1, 1'b1};
        v[2] = '{4'b0111, 4'b0000, 1'b1, 4'b0111, 1'b1, 1'b0};
        v[4] = '{4'b1000, 4'b1000, 1'b0, 4'b1000, 1'b1, 1'b1};
`else
        v[1] = '{4'b1100, 4'b1011, 1'b0, 4'b0111, 1'b1, 1'b1};
        v[2] = '{4'b0111, 4'b0000, 1'b1, 4'b1000, 1'b1, 1'b0};
        v[4] = '{4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1};
`endif
        v[3] = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            step(v[i].a, v[i].b, v[i].c);
            checks++;
            if ({SUM, Overflow, Cout} !== {v[i].sum, v[i].ovf, v[i].cout}) begin
                errors++;
                $display("FAIL directed%0d %b+%b+%b: got SUM=%b Ovf=%b Cout=%b, want SUM=%b Ovf=%b Cout=%b",
                         i, v[i].a, v[i].b, v[i].c, SUM, Overflow, Cout, v[i].sum, v[i].ovf, v[i].cout);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t v[3];
        v[0] = '{4'b0011, 4'b0010, 1'b0, 4'b0101, 1'b0, 1'b0};
        v[1] = '{4'b0110, 4'b1101, 1'b1, 4'b0100, 1'b0, 1'b1};
        v[2] = '{4'b1010, 4'b0101, 1'b0, 4'b1111, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            step(v[i].a, v[i].b, v[i].c);
            checks++;
            if ({SUM, Overflow, Cout} !== {v[i].sum, v[i].ovf, v[i].cout}) begin
                errors++;
                $display("FAIL b2b%0d: got SUM=%b Ovf=%b Cout=%b, want SUM=%b Ovf=%b Cout=%b",
                         i, SUM, Overflow, Cout, v[i].sum, v[i].ovf, v[i].cout);
            end
        end
        // Reset edge with live inputs that would otherwise set every output.
        rst = 1'b1;
        step(4'b1000, 4'b1000, 1'b1);
        checks++;
        if ({SUM, Overflow, Cout} !== 6'b0000_0_0) begin
            errors++;
            $display("FAIL b2b_reset: got SUM=%b Ovf=%b Cout=%b, want SUM=0000 Ovf=0 Cout=0",
                     SUM, Overflow, Cout);
        end
        // First edge after deassertion yields a valid result.
        rst = 1'b0;
        step(4'b0001, 4'b0001, 1'b1);
        checks++;
        if ({SUM, Overflow, Cout} !== 6'b0011_0_0) begin
            errors++;
            $display("FAIL post_reset_first: got SUM=%b Ovf=%b Cout=%b, want SUM=0011 Ovf=0 Cout=0",
                     SUM, Overflow, Cout);
        end
    endtask

    task automatic test_sweep();
        logic [3:0] a, b;
        logic       c;
        logic [5:0] exp_v;
        for (int n = 0; n < 512; n++) begin
            a = n[7:4];
            b = n[3:0];
            c = n[8];
            exp_v = model(a, b, c);
            step(a, b, c);
            checks++;
            if ({SUM, Overflow, Cout} !== exp_v) begin
                errors++;
                $display("FAIL sweep %b+%b+%b: got SUM=%b Ovf=%b Cout=%b, want SUM=%b Ovf=%b Cout=%b",
                         a, b, c, SUM, Overflow, Cout, exp_v[5:2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        A   = 4'b0000;
        B   = 4'b0000;
        C0  = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
